// File: rtl/qed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qed_pkg
// Description : Shared constants, FSM state encoding and EDDI-V register
//               remap helpers for the QED duplicating instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package qed_pkg;

  // RISC-V major opcodes that have an EDDI-V duplicate
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  // Instruction field positions
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_W   = 5;

  // Duplicates live in the upper half of the register file
  localparam logic [4:0] QED_REG_OFFSET = 5'd16;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DUP   = 2'd1,
    S_DONE  = 2'd2
  } qed_state_t;

  // True when the instruction has a register-renamed duplicate
  function automatic logic qed_dupable(input logic [31:0] instr);
    logic w_dup;
    w_dup = 1'b0;
    case (instr[OPC_LSB +: OPC_W])
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_LUI: w_dup = 1'b1;
      default:                                    w_dup = 1'b0;
    endcase
    return w_dup;
  endfunction

  // x0 stays x0; any other register moves into x16..x31 (idempotent OR)
  function automatic logic [4:0] qed_remap_reg(input logic [4:0] reg_idx);
    return (reg_idx == 5'd0) ? reg_idx : (reg_idx | QED_REG_OFFSET);
  endfunction

  // Build the duplicate: remap only the register fields the format uses,
  // so immediates that share those bit positions pass through untouched
  function automatic logic [31:0] qed_remap(input logic [31:0] instr);
    logic [31:0] w_out;
    logic        w_rd;
    logic        w_rs1;
    logic        w_rs2;
    w_out = instr;
    w_rd  = 1'b0;
    w_rs1 = 1'b0;
    w_rs2 = 1'b0;
    case (instr[OPC_LSB +: OPC_W])
      OPC_R: begin
        w_rd  = 1'b1;
        w_rs1 = 1'b1;
        w_rs2 = 1'b1;
      end
      OPC_I, OPC_LOAD: begin
        w_rd  = 1'b1;
        w_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_rs1 = 1'b1;
        w_rs2 = 1'b1;
      end
      OPC_LUI: w_rd = 1'b1;
      default: w_rd = 1'b0;
    endcase
    if (w_rd)  w_out[RD_LSB  +: REG_W] = qed_remap_reg(instr[RD_LSB  +: REG_W]);
    if (w_rs1) w_out[RS1_LSB +: REG_W] = qed_remap_reg(instr[RS1_LSB +: REG_W]);
    if (w_rs2) w_out[RS2_LSB +: REG_W] = qed_remap_reg(instr[RS2_LSB +: REG_W]);
    return w_out;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qed_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : qed_sync_fifo
// Description : Single-clock FIFO with power-of-two depth, wrapping pointers
//               and an occupancy count one bit wider than the pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module qed_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == C_DEPTH);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  // Overflow / underflow requests are ignored rather than corrupting state
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  // Storage array; contents need no reset because the count guards reads
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy tracks simultaneous push and pop as no change
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/qed_dup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qed_dup_sequencer
// Description : Buffers the original instruction stream and emits each word
//               followed, when enabled, by its EDDI-V duplicate, stopping once
//               the instruction memory word budget is used up.
// Revision    : 1.0 - initial release
// ============================================================================
module qed_dup_sequencer
  import qed_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_vld_i,
  input  logic [31:0] instr_i,
  output logic        instr_rdy_o,
  input  logic        qed_ena_i,
  output logic        qed_vld_o,
  output logic [31:0] qed_instr_o,
  output logic        done_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WC_W  = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] C_FIFO_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]  C_MAX_WORDS  = WC_W'(MAX_WORDS);

  qed_state_t       r_state;
  qed_state_t       w_next_state;
  logic [WC_W-1:0]  r_word_count;
  logic [WC_W-1:0]  w_count_next;
  logic [WC_W-1:0]  w_remaining;
  logic [WC_W-1:0]  w_need;
  logic [31:0]      r_hold;
  logic [31:0]      w_fifo_head;
  logic [31:0]      w_emit_word;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  logic             w_unused_fifo_full;
  logic             w_push;
  logic             w_pop;
  logic             w_emit;

  // Ready ignores a same-cycle pop: a full FIFO never accepts
  assign done_o       = (r_state == S_DONE);
  assign instr_rdy_o  = (w_fifo_count < C_FIFO_DEPTH) && !done_o;
  assign w_push       = instr_vld_i && instr_rdy_o;
  assign w_remaining  = C_MAX_WORDS - r_word_count;
  assign w_count_next = r_word_count + WC_W'(1);
  assign w_need       = (qed_ena_i && qed_dupable(w_fifo_head)) ? WC_W'(2) : WC_W'(1);

  qed_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (instr_i),
    .data_o  (w_fifo_head),
    .full_o  (w_unused_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_FETCH;
    else         r_state <= w_next_state;
  end

  // Next state, pop and emit decisions; an original is only taken when its
  // whole pair fits in the remaining budget so a pair is never split
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_emit       = 1'b0;
    w_emit_word  = w_fifo_head;
    unique case (r_state)
      S_FETCH: begin
        if (!w_fifo_empty) begin
          if (w_remaining >= w_need) begin
            w_pop  = 1'b1;
            w_emit = 1'b1;
            if (w_need == WC_W'(2))          w_next_state = S_DUP;
            else if (w_count_next == C_MAX_WORDS) w_next_state = S_DONE;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DUP: begin
        w_emit       = 1'b1;
        w_emit_word  = qed_remap(r_hold);
        w_next_state = (w_count_next == C_MAX_WORDS) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Emitted-word counter; emits only happen with budget left, so no wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_word_count <= '0;
    else if (w_emit) r_word_count <= w_count_next;
  end

  // Keep the popped original so its duplicate can be formed next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_hold <= '0;
    else if (w_pop) r_hold <= w_fifo_head;
  end

  // Registered output stream; the word holds its value between emits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qed_vld_o   <= 1'b0;
      qed_instr_o <= '0;
    end else begin
      qed_vld_o <= w_emit;
      if (w_emit) qed_instr_o <= w_emit_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qed_dup_sequencer
// Description : Directed self-checking bench for qed_dup_sequencer using two
//               instances (large and 3-word instruction memory budgets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qed_dup_sequencer;

  logic        clk;
  logic        rst_n;

  logic        a_vld, a_rdy, a_ena, a_qvld, a_done;
  logic [31:0] a_instr, a_qinstr;
  logic        b_vld, b_rdy, b_ena, b_qvld, b_done;
  logic [31:0] b_instr, b_qinstr;

  int n_vec;
  int n_err;

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];

  // Backpressure stream: originals and hand-computed duplicates
  logic [31:0] bp_orig [8];
  logic [31:0] bp_dup  [8];

  qed_dup_sequencer #(.FIFO_DEPTH(4), .MAX_WORDS(256)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .instr_vld_i (a_vld),
    .instr_i     (a_instr),
    .instr_rdy_o (a_rdy),
    .qed_ena_i   (a_ena),
    .qed_vld_o   (a_qvld),
    .qed_instr_o (a_qinstr),
    .done_o      (a_done)
  );

  qed_dup_sequencer #(.FIFO_DEPTH(4), .MAX_WORDS(3)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .instr_vld_i (b_vld),
    .instr_i     (b_instr),
    .instr_rdy_o (b_rdy),
    .qed_ena_i   (b_ena),
    .qed_vld_o   (b_qvld),
    .qed_instr_o (b_qinstr),
    .done_o      (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every emitted word, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (a_qvld === 1'b1) a_q.push_back(a_qinstr);
    if (b_qvld === 1'b1) b_q.push_back(b_qinstr);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    if (i < a_q.size()) return a_q[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] qb(input int i);
    if (i < b_q.size()) return b_q[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic rdy_s;
    logic saw_full;
    int   idx;
    int   guard;

    n_vec = 0;
    n_err = 0;
    // add x1,x2,x3 / addi x4,x4,1 / lw x5,8(x6) / lui x7,0x12345
    // sub x0,x1,x2 (rd=x0 kept) / sw x3,4(x0) (imm in rd slot kept)
    // xori x9,x10,-1 / or x15,x14,x13
    bp_orig[0] = 32'h003100B3; bp_dup[0] = 32'h013908B3;
    bp_orig[1] = 32'h00120213; bp_dup[1] = 32'h001A0A13;
    bp_orig[2] = 32'h00832283; bp_dup[2] = 32'h008B2A83;
    bp_orig[3] = 32'h123453B7; bp_dup[3] = 32'h12345BB7;
    bp_orig[4] = 32'h40208033; bp_dup[4] = 32'h41288033;
    bp_orig[5] = 32'h00302223; bp_dup[5] = 32'h01302223;
    bp_orig[6] = 32'hFFF54493; bp_dup[6] = 32'hFFFD4C93;
    bp_orig[7] = 32'h00D767B3; bp_dup[7] = 32'h01DF6FB3;

    a_vld = 1'b0; a_instr = '0; a_ena = 1'b0;
    b_vld = 1'b0; b_instr = '0; b_ena = 1'b0;
    rst_n = 1'b0;

    // ---- reset state ----
    #2;
    check_vec("rst_vld",   {31'b0, a_qvld},  32'd0);
    check_vec("rst_instr", a_qinstr,         32'd0);
    check_vec("rst_done",  {31'b0, a_done},  32'd0);
    check_vec("rst_rdy",   {31'b0, a_rdy},   32'd1);
    do_reset();
    check_vec("rst_vld_post", {31'b0, a_qvld}, 32'd0);

    // ---- enabled R-type: add x3,x1,x2 -> add x19,x17,x18 ----
    a_ena = 1'b1; a_vld = 1'b1; a_instr = 32'h002081B3;
    @(posedge clk); #1;
    a_vld = 1'b0;
    check_vec("r_lat0_vld", {31'b0, a_qvld}, 32'd0);
    cyc(1);
    check_vec("r_orig_vld", {31'b0, a_qvld}, 32'd1);
    check_vec("r_orig",     a_qinstr,        32'h002081B3);
    cyc(1);
    check_vec("r_dup_vld",  {31'b0, a_qvld}, 32'd1);
    check_vec("r_dup",      a_qinstr,        32'h012889B3);
    cyc(1);
    check_vec("r_idle_vld", {31'b0, a_qvld}, 32'd0);
    check_vec("r_hold",     a_qinstr,        32'h012889B3);
    cyc(2);

    // ---- disabled: addi x5,x0,7 emitted once ----
    a_q.delete();
    a_ena = 1'b0; a_vld = 1'b1; a_instr = 32'h00700293;
    @(posedge clk); #1;
    a_vld = 1'b0;
    cyc(5);
    check_vec("dis_n",    32'(a_q.size()), 32'd1);
    check_vec("dis_word", qa(0),           32'h00700293);

    // ---- mixed: sw x2,0(x1) then beq x1,x2,0 ----
    a_q.delete();
    a_ena = 1'b1; a_vld = 1'b1; a_instr = 32'h0020A023;
    @(posedge clk); #1;
    a_instr = 32'h00208063;
    @(posedge clk); #1;
    a_vld = 1'b0;
    cyc(6);
    check_vec("mix_n",  32'(a_q.size()), 32'd3);
    check_vec("mix_w0", qa(0),           32'h0020A023);
    check_vec("mix_w1", qa(1),           32'h0128A023);
    check_vec("mix_w2", qa(2),           32'h00208063);

    // ---- backpressure: offer eight dupables back to back ----
    a_q.delete();
    a_ena = 1'b1; idx = 0; guard = 0; saw_full = 1'b0;
    while (idx < 8 && guard < 100) begin
      a_vld   = 1'b1;
      a_instr = bp_orig[idx];
      rdy_s   = a_rdy;
      if (!rdy_s) saw_full = 1'b1;
      @(posedge clk); #1;
      guard++;
      if (rdy_s) idx++;
    end
    a_vld = 1'b0;
    check_vec("bp_accepted", 32'(idx),          32'd8);
    check_vec("bp_saw_full", {31'b0, saw_full}, 32'd1);
    cyc(30);
    check_vec("bp_n", 32'(a_q.size()), 32'd16);
    for (int i = 0; i < 8; i++) begin
      check_vec("bp_orig", qa(2 * i),     bp_orig[i]);
      check_vec("bp_dup",  qa(2 * i + 1), bp_dup[i]);
    end
    check_vec("bp_rdy_end", {31'b0, a_rdy}, 32'd1);

    // ---- budget on 3-word memory: second pair does not fit ----
    b_q.delete();
    b_ena = 1'b1; b_vld = 1'b1; b_instr = 32'h002081B3;
    @(posedge clk); #1;
    b_instr = 32'h00700293;
    @(posedge clk); #1;
    b_vld = 1'b0;
    cyc(6);
    check_vec("bud_n",     32'(b_q.size()),  32'd2);
    check_vec("bud_w0",    qb(0),            32'h002081B3);
    check_vec("bud_w1",    qb(1),            32'h012889B3);
    check_vec("bud_done",  {31'b0, b_done},  32'd1);
    check_vec("bud_rdy",   {31'b0, b_rdy},   32'd0);
    check_vec("bud_hold",  b_qinstr,         32'h012889B3);

    // ---- reset clears done; exact budget reach asserts done with last word ----
    do_reset();
    check_vec("bud_rst_done", {31'b0, b_done}, 32'd0);
    b_q.delete();
    b_ena = 1'b0; b_vld = 1'b1; b_instr = 32'h00700293;
    @(posedge clk); #1;
    b_instr = 32'h00208063;
    @(posedge clk); #1;
    b_instr = 32'h00100073;
    @(posedge clk); #1;
    b_vld = 1'b0;
    check_vec("ex_w1",       b_qinstr,        32'h00208063);
    check_vec("ex_done_pre", {31'b0, b_done}, 32'd0);
    cyc(1);
    check_vec("ex_w2_vld",   {31'b0, b_qvld}, 32'd1);
    check_vec("ex_w2",       b_qinstr,        32'h00100073);
    check_vec("ex_done",     {31'b0, b_done}, 32'd1);
    cyc(1);
    check_vec("ex_idle_vld", {31'b0, b_qvld}, 32'd0);

    // ---- reset in the cycle after an original is emitted ----
    a_ena = 1'b1; a_vld = 1'b1; a_instr = 32'h002081B3;
    @(posedge clk); #1;
    a_instr = 32'h003100B3;
    @(posedge clk); #1;
    a_vld = 1'b0;
    check_vec("mr_orig", a_qinstr, 32'h002081B3);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("mr_async_vld",   {31'b0, a_qvld}, 32'd0);
    check_vec("mr_async_instr", a_qinstr,        32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_q.delete();
    cyc(6);
    check_vec("mr_no_words", 32'(a_q.size()), 32'd0);
    check_vec("mr_done",     {31'b0, a_done}, 32'd0);
    check_vec("mr_rdy",      {31'b0, a_rdy},  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
